mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Memory-side responder for the byte-wide unified RAM. Serves three requesters:
//   - instruction fetch (IF): 4-byte reads.
//   - LSB loads: 1/2/4-byte reads, signed or unsigned.
//   - ROB-committed stores: 1/2/4-byte writes.
//  Each request is latched from a one-cycle pulse and arbitrated. The block serialises
//  bytes over mem_a/mem_din/mem_dout, reassembles or extends read data, and returns a
//  one-cycle done pulse to the owner.
// PARAMETERS
//  ADDR_W   32     address width
//  DATA_W   32     data width of requester ports
//  IO_SEL   2'b11  value of addr[17:16] that marks the IO region
// PORTS
//  clk             in   1       clock
//  rst             in   1       reset, synchronous, active-high
//  rdy             in   1       global enable; 0 = freeze
//  clear           in   1       pipeline flush (mispredict)
//  if_req          in   1       fetch request pulse
//  if_addr         in   32      fetch address
//  if_done         out  1       fetch complete pulse
//  if_data         out  32      fetched word, valid with if_done
//  ld_req          in   1       load request pulse
//  ld_size         in   6       load size in bytes: 1, 2 or 4
//  ld_signed       in   1       1 = sign-extend, 0 = zero-extend
//  ld_addr         in   32      load address
//  ld_done         out  1       load complete pulse
//  ld_data         out  32      load result, valid with ld_done
//  st_req          in   1       store request pulse
//  st_size         in   6       store size in bytes: 1, 2 or 4
//  st_addr         in   32      store address
//  st_data         in   32      store data; byte 0 = st_data[7:0]
//  st_done         out  1       store complete pulse
//  io_buffer_full  in   1       IO write buffer full
//  mem_din         in   8       RAM read byte
//  mem_dout        out  8       RAM write byte
//  mem_a           out  32      RAM byte address
//  mem_wr          out  1       1 = write, 0 = read
// BEHAVIOUR
//  Reset/clear values
//  - On rst, all outputs and registers are 0: state IDLE, no pending requests.
//  Request latching
//  - A *_req pulse sets the port's pending flag and latches addr/size/signed/data.
//  - A request on a port whose flag is already set is ignored; requesters never do this.
//  - A req in the same cycle as that port's done pulse is latched normally.
//  Arbitration (in IDLE only)
//  - Priority: store > load > fetch.
//  - A store is not granted while io_buffer_full=1 and st_addr[17:16]==IO_SEL;
//    a pending load or fetch is granted instead.
//  State machine
//  - States: IDLE, READ, WRITE. Byte counter cnt is 0..size.
//  - READ: grant edge E0 sets mem_a<=addr and mem_wr<=0. After edge Ek,
//    mem_a = addr+k for k < n. The RAM has 1-cycle read latency, so byte i is sampled
//    from mem_din at edge E(i+2) into result[8i+7:8i].
//  - READ end: at E(n+1), done<=1 and data is driven for one cycle, state<=IDLE,
//    mem_a<=0. Latency is n+1 cycles from E0; the earliest next grant is E(n+2).
//  - WRITE: at E0, mem_wr<=1, mem_a<=addr, mem_dout<=data[7:0]. At Ek (k<n),
//    byte k goes to addr+k.
//  - WRITE end: at En, mem_wr<=0, mem_dout<=0, st_done<=1, state<=IDLE.
//  Load data formatting
//  - Unused upper bits are zero-filled when ld_signed=0.
//  - When ld_signed=1 they are filled with bit 8n-1.
//  - if_data is always 4 bytes, little-endian.
//  Freeze (rdy=0)
//  - All registers hold and mem_wr is gated to 0.
//  - The current byte is re-issued once rdy returns.
//  Flush (clear=1)
//  - Drops the load/fetch pending flags and aborts an in-flight READ:
//    state<=IDLE, mem_a<=0, no done pulse.
//  - req pulses in the same cycle as clear are discarded.
//  - A pending or in-flight store is unaffected (already committed).
//  - rst mid-operation aborts everything, including a store; it takes effect at the edge.
//  Pulse guarantees
//  - Done pulses last exactly one cycle. At most one done fires per cycle.
//  - Address arithmetic wraps modulo 2^32.
// TESTING
//  1. ld_req, ld_size=4, addr 0x100, RAM[0x100..103]=78 56 34 12 -> ld_done 5 cycles after grant, ld_data=0x12345678.
//  2. LB signed at 0x200 holding 0x80 -> ld_data=0xFFFFFF80; LBU -> 0x00000080; LH at 0x200 with RAM[0x201]=0xFF -> 0xFFFFFF80.
//  3. st_req SW 0xDEADBEEF @0x300 -> mem_wr=1 for 4 cycles with bytes EF BE AD DE at 0x300..303, then st_done; LW reads back the value.
//  4. st_req, ld_req, if_req in the same cycle -> grant order store, then load, then fetch; each done fires exactly once.
//  5. clear 2 cycles into an LW -> no ld_done, mem_a=0, IDLE next cycle; a concurrent pending SW still completes with st_done.
//  6. SB to 0x30000 with io_buffer_full=1 -> mem_wr stays 0 and a pending fetch is served; after full drops, the store is written, then st_done.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus bundle between the requesters, the RAM and mem_ctrl.
// master: requesters plus RAM side (drives reqs, mem_din); slave: mem_ctrl.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rdy;
    logic              clear;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_data;
    logic              ld_req;
    logic [5:0]        ld_size;
    logic              ld_signed;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_done;
    logic [DATA_W-1:0] ld_data;
    logic              st_req;
    logic [5:0]        st_size;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_done;
    logic              io_buffer_full;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        output rdy, clear,
        output if_req, if_addr,
        output ld_req, ld_size, ld_signed, ld_addr,
        output st_req, st_size, st_addr, st_data,
        output io_buffer_full, mem_din,
        input  if_done, if_data, ld_done, ld_data, st_done,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  rdy, clear,
        input  if_req, if_addr,
        input  ld_req, ld_size, ld_signed, ld_addr,
        input  st_req, st_size, st_addr, st_data,
        input  io_buffer_full, mem_din,
        output if_done, if_data, ld_done, ld_data, st_done,
        output mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM responder for fetch, load and store requesters.
// Ports: clk, rst (sync, active-high), io_bus (mem_ctrl_if.slave).
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave io_bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_IF   = 2'd1,
        G_LD   = 2'd2,
        G_ST   = 2'd3
    } grant_t;

    state_t            r_state;
    state_t            w_state_nxt;
    grant_t            w_grant;

    logic              r_if_pend;
    logic [ADDR_W-1:0] r_if_addr;
    logic              r_ld_pend;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [5:0]        r_ld_size;
    logic              r_ld_signed;
    logic              r_st_pend;
    logic [ADDR_W-1:0] r_st_addr;
    logic [5:0]        r_st_size;
    logic [DATA_W-1:0] r_st_data;

    logic              r_is_ld;
    logic [ADDR_W-1:0] r_addr;
    logic [5:0]        r_n;
    logic              r_sgn;
    logic [DATA_W-1:0] r_wdata;
    logic [5:0]        r_cnt;
    logic [23:0]       r_res;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic              r_mem_wr;
    logic              r_if_done;
    logic              r_ld_done;
    logic              r_st_done;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_ld_data;

    logic              w_is_ld_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [5:0]        w_n_nxt;
    logic              w_sgn_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [5:0]        w_cnt_nxt;
    logic [23:0]       w_res_nxt;
    logic [ADDR_W-1:0] w_mem_a_nxt;
    logic [7:0]        w_dout_nxt;
    logic              w_wr_nxt;
    logic              w_if_done_nxt;
    logic              w_ld_done_nxt;
    logic              w_st_done_nxt;
    logic [DATA_W-1:0] w_if_data_nxt;
    logic [DATA_W-1:0] w_ld_data_nxt;

    logic              w_st_ok;
    logic              w_ld_ok;
    logic              w_if_ok;
    logic              w_rd_last;
    logic              w_wr_last;
    logic [23:0]       w_fill;
    logic [DATA_W-1:0] w_fmt;
    logic [7:0]        w_wbyte;

    // IO stores wait while the IO write buffer is full.
    assign w_st_ok = r_st_pend &&
        !(io_bus.io_buffer_full &&
          (r_st_addr[17:16] == IO_SEL));
    assign w_ld_ok = r_ld_pend && !io_bus.clear;
    assign w_if_ok = r_if_pend && !io_bus.clear;

    // r_cnt holds the index k of the upcoming edge Ek.
    assign w_rd_last = (r_cnt == r_n + 6'd1);
    assign w_wr_last = (r_cnt == r_n);

    // The final byte is taken straight from mem_din; it also
    // carries the sign bit 8n-1 for every size.
    always_comb begin
        w_fill = {24{r_sgn & io_bus.mem_din[7]}};
        case (r_n)
            6'd1:    w_fmt = {w_fill, io_bus.mem_din};
            6'd2:    w_fmt = {w_fill[15:0], io_bus.mem_din,
                              r_res[7:0]};
            default: w_fmt = {io_bus.mem_din, r_res};
        endcase
    end

    always_comb begin
        case (r_cnt[1:0])
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            2'd3:    w_wbyte = r_wdata[31:24];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (io_bus.rdy) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = G_NONE;
        unique case (r_state)
            S_IDLE: begin
                if (w_st_ok) begin
                    w_grant     = G_ST;
                    w_state_nxt = S_WRITE;
                end else if (w_ld_ok) begin
                    w_grant     = G_LD;
                    w_state_nxt = S_READ;
                end else if (w_if_ok) begin
                    w_grant     = G_IF;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (io_bus.clear || w_rd_last)
                    w_state_nxt = S_IDLE;
            end
            S_WRITE: begin
                if (w_wr_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_is_ld_nxt   = r_is_ld;
        w_addr_nxt    = r_addr;
        w_n_nxt       = r_n;
        w_sgn_nxt     = r_sgn;
        w_wdata_nxt   = r_wdata;
        w_cnt_nxt     = r_cnt;
        w_res_nxt     = r_res;
        w_mem_a_nxt   = r_mem_a;
        w_dout_nxt    = r_mem_dout;
        w_wr_nxt      = r_mem_wr;
        w_if_done_nxt = 1'b0;
        w_ld_done_nxt = 1'b0;
        w_st_done_nxt = 1'b0;
        w_if_data_nxt = '0;
        w_ld_data_nxt = '0;
        unique case (r_state)
            S_IDLE: begin
                unique case (w_grant)
                    G_ST: begin
                        w_addr_nxt  = r_st_addr;
                        w_n_nxt     = r_st_size;
                        w_wdata_nxt = r_st_data;
                        w_mem_a_nxt = r_st_addr;
                        w_dout_nxt  = r_st_data[7:0];
                        w_wr_nxt    = 1'b1;
                        w_cnt_nxt   = 6'd1;
                    end
                    G_LD: begin
                        w_is_ld_nxt = 1'b1;
                        w_addr_nxt  = r_ld_addr;
                        w_n_nxt     = r_ld_size;
                        w_sgn_nxt   = r_ld_signed;
                        w_mem_a_nxt = r_ld_addr;
                        w_wr_nxt    = 1'b0;
                        w_cnt_nxt   = 6'd1;
                        w_res_nxt   = '0;
                    end
                    G_IF: begin
                        w_is_ld_nxt = 1'b0;
                        w_addr_nxt  = r_if_addr;
                        w_n_nxt     = 6'd4;
                        w_sgn_nxt   = 1'b0;
                        w_mem_a_nxt = r_if_addr;
                        w_wr_nxt    = 1'b0;
                        w_cnt_nxt   = 6'd1;
                        w_res_nxt   = '0;
                    end
                    default: ;
                endcase
            end
            S_READ: begin
                if (io_bus.clear) begin
                    w_mem_a_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (w_rd_last) begin
                    if (r_is_ld) begin
                        w_ld_done_nxt = 1'b1;
                        w_ld_data_nxt = w_fmt;
                    end else begin
                        w_if_done_nxt = 1'b1;
                        w_if_data_nxt = w_fmt;
                    end
                    w_mem_a_nxt = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_cnt < r_n)
                        w_mem_a_nxt = r_addr + ADDR_W'(r_cnt);
                    // RAM data lags the address by two edges.
                    case (r_cnt)
                        6'd2:    w_res_nxt[7:0]   = io_bus.mem_din;
                        6'd3:    w_res_nxt[15:8]  = io_bus.mem_din;
                        6'd4:    w_res_nxt[23:16] = io_bus.mem_din;
                        default: ;
                    endcase
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_WRITE: begin
                if (w_wr_last) begin
                    w_wr_nxt      = 1'b0;
                    w_dout_nxt    = '0;
                    w_mem_a_nxt   = '0;
                    w_st_done_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_mem_a_nxt = r_addr + ADDR_W'(r_cnt);
                    w_dout_nxt  = w_wbyte;
                    w_cnt_nxt   = r_cnt + 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_pend   <= 1'b0;
            r_if_addr   <= '0;
            r_ld_pend   <= 1'b0;
            r_ld_addr   <= '0;
            r_ld_size   <= '0;
            r_ld_signed <= 1'b0;
            r_st_pend   <= 1'b0;
            r_st_addr   <= '0;
            r_st_size   <= '0;
            r_st_data   <= '0;
        end else if (io_bus.rdy) begin
            if (w_grant == G_ST) begin
                r_st_pend <= 1'b0;
            end else if (io_bus.st_req && !r_st_pend) begin
                r_st_pend <= 1'b1;
                r_st_addr <= io_bus.st_addr;
                r_st_size <= io_bus.st_size;
                r_st_data <= io_bus.st_data;
            end
            // Flush drops speculative requests, including new ones.
            if (io_bus.clear || w_grant == G_LD) begin
                r_ld_pend <= 1'b0;
            end else if (io_bus.ld_req && !r_ld_pend) begin
                r_ld_pend   <= 1'b1;
                r_ld_addr   <= io_bus.ld_addr;
                r_ld_size   <= io_bus.ld_size;
                r_ld_signed <= io_bus.ld_signed;
            end
            if (io_bus.clear || w_grant == G_IF) begin
                r_if_pend <= 1'b0;
            end else if (io_bus.if_req && !r_if_pend) begin
                r_if_pend <= 1'b1;
                r_if_addr <= io_bus.if_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_ld    <= 1'b0;
            r_addr     <= '0;
            r_n        <= '0;
            r_sgn      <= 1'b0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_res      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ld_done  <= 1'b0;
            r_st_done  <= 1'b0;
            r_if_data  <= '0;
            r_ld_data  <= '0;
        end else if (io_bus.rdy) begin
            r_is_ld    <= w_is_ld_nxt;
            r_addr     <= w_addr_nxt;
            r_n        <= w_n_nxt;
            r_sgn      <= w_sgn_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_res      <= w_res_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_dout_nxt;
            r_mem_wr   <= w_wr_nxt;
            r_if_done  <= w_if_done_nxt;
            r_ld_done  <= w_ld_done_nxt;
            r_st_done  <= w_st_done_nxt;
            r_if_data  <= w_if_data_nxt;
            r_ld_data  <= w_ld_data_nxt;
        end
    end

    assign io_bus.if_done  = r_if_done;
    assign io_bus.if_data  = r_if_data;
    assign io_bus.ld_done  = r_ld_done;
    assign io_bus.ld_data  = r_ld_data;
    assign io_bus.st_done  = r_st_done;
    assign io_bus.mem_a    = r_mem_a;
    assign io_bus.mem_dout = r_mem_dout;
    // A frozen write byte must not reach the RAM.
    assign io_bus.mem_wr   = r_mem_wr & io_bus.rdy;

endmodule
